// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/acknowledge interface between the MEM stage and memory.
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/load_align.sv
// Combinational load alignment: lane select by byte offset, then sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  mask_i,
  input  logic        sign_extend_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (mask_i)
      MASK_BYTE: result_o = {{24{sign_extend_i & shifted[7]}}, shifted[7:0]};
      MASK_HALF: result_o = {{16{sign_extend_i & shifted[15]}}, shifted[15:0]};
      default:   result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one req/ack bus transaction per access, stalls the
// pipeline while it is in flight, and reports misaligned/illegal accesses and timeouts.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ex_mem_alu_result,
  input  logic               ex_mem_mem_read,
  input  logic               ex_mem_mem_write,
  input  logic [3:0]         ex_mem_mem_data_mask,
  input  logic               ex_mem_mem_read_sign_extend,
  input  logic [31:0]        ex_mem_mem_write_data,
  mem_access_unit_if.master  bus,
  output logic               mem_stall,
  output logic [31:0]        mem_load_data,
  output logic               mem_fault,
  output logic               mem_fault_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  mem_state_t  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        sext_q, sext_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fault_q, fault_d;
  logic        fault_to_q, fault_to_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        acc, illegal, misaligned, timeout_hit;
  logic [31:0] aligned;

  assign acc        = ex_mem_mem_read | ex_mem_mem_write;
  assign illegal    = (ex_mem_mem_read & ex_mem_mem_write) |
                      ~((ex_mem_mem_data_mask == MASK_BYTE) |
                        (ex_mem_mem_data_mask == MASK_HALF) |
                        (ex_mem_mem_data_mask == MASK_WORD));
  assign misaligned = ((ex_mem_mem_data_mask == MASK_HALF) & ex_mem_alu_result[0]) |
                      ((ex_mem_mem_data_mask == MASK_WORD) & (ex_mem_alu_result[1:0] != 2'b00));
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Alignment uses the access attributes captured at issue, not the live EX/MEM inputs.
  load_align u_load_align (
    .rdata_i       (bus.bus_rdata),
    .addr_lo_i     (addr_lo_q),
    .mask_i        (mask_q),
    .sign_extend_i (sext_q),
    .result_o      (aligned)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    mask_d      = mask_q;
    addr_lo_d   = addr_lo_q;
    sext_d      = sext_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    fault_to_d  = 1'b0;
    cnt_d       = cnt_q;
    mem_stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc) begin
          mem_stall = 1'b1;
          state_d   = DONE;
          if (illegal | misaligned) begin
            fault_d = 1'b1;
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = ex_mem_mem_write;
            bus_addr_d  = {ex_mem_alu_result[31:2], 2'b00};
            bus_wdata_d = ex_mem_mem_write_data << {ex_mem_alu_result[1:0], 3'b000};
            bus_wstrb_d = ex_mem_mem_write ? (ex_mem_mem_data_mask << ex_mem_alu_result[1:0])
                                           : 4'b0000;
            mask_d      = ex_mem_mem_data_mask;
            addr_lo_d   = ex_mem_alu_result[1:0];
            sext_d      = ex_mem_mem_read_sign_extend;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        // An ack arriving on the timeout cycle still completes normally.
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          if (!bus_we_q) load_data_d = aligned;
        end else if (timeout_hit) begin
          bus_req_d  = 1'b0;
          fault_d    = 1'b1;
          fault_to_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      mask_q      <= '0;
      addr_lo_q   <= '0;
      sext_q      <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      fault_to_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      mask_q      <= mask_d;
      addr_lo_q   <= addr_lo_d;
      sext_q      <= sext_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      fault_to_q  <= fault_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.bus_req        = bus_req_q;
  assign bus.bus_we         = bus_we_q;
  assign bus.bus_addr       = bus_addr_q;
  assign bus.bus_wdata      = bus_wdata_q;
  assign bus.bus_wstrb      = bus_wstrb_q;
  assign mem_load_data      = load_data_q;
  assign mem_fault          = fault_q;
  assign mem_fault_timeout  = fault_to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model driven per cycle,
// directed scenarios with literal expectations, then randomized accesses.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, wd;
  logic        rd, wr, sx;
  logic [3:0]  mask;
  logic        stall, fault, fto;
  logic [31:0] ld;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_EN(1'b1)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .ex_mem_alu_result           (alu),
    .ex_mem_mem_read             (rd),
    .ex_mem_mem_write            (wr),
    .ex_mem_mem_data_mask        (mask),
    .ex_mem_mem_read_sign_extend (sx),
    .ex_mem_mem_write_data       (wd),
    .bus                         (bus),
    .mem_stall                   (stall),
    .mem_load_data               (ld),
    .mem_fault                   (fault),
    .mem_fault_timeout           (fto)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Per-cycle expectations published by the stimulus, consumed by the compare process.
  logic        exp_on = 1'b0;
  logic        exp_stall, exp_req, exp_fault, exp_fto, exp_we;
  logic [31:0] exp_ld, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] model_ld;

  int          stall_cnt, req_cnt, fault_cnt, fto_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("bus_req", 32'(bus.bus_req), 32'(exp_req));
      check("fault", 32'(fault), 32'(exp_fault));
      check("fault_timeout", 32'(fto), 32'(exp_fto));
      check("load_data", ld, exp_ld);
      if (exp_req) begin
        check("bus_we", 32'(bus.bus_we), 32'(exp_we));
        check("bus_addr", bus.bus_addr, exp_addr);
        check("bus_wstrb", 32'(bus.bus_wstrb), 32'(exp_wstrb));
        if (exp_we) check("bus_wdata", bus.bus_wdata, exp_wdata);
      end
    end
    if (stall === 1'b1) stall_cnt++;
    if (fault === 1'b1) fault_cnt++;
    if (fto === 1'b1) fto_cnt++;
    if (bus.bus_req === 1'b1) begin
      req_cnt++;
      cap_addr  = bus.bus_addr;
      cap_wdata = bus.bus_wdata;
      cap_wstrb = bus.bus_wstrb;
      cap_we    = bus.bus_we;
    end
  end

  function automatic logic [31:0] model_align(input logic [31:0] rdata, input int off,
                                              input logic [3:0] m, input logic s);
    logic [31:0] v;
    v = rdata >> (8 * off);
    if (m == 4'b0001) begin
      v = v & 32'h0000_00FF;
      if (s && v[7]) v = v | 32'hFFFF_FF00;
    end else if (m == 4'b0011) begin
      v = v & 32'h0000_FFFF;
      if (s && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic clr();
    stall_cnt = 0; req_cnt = 0; fault_cnt = 0; fto_cnt = 0;
  endtask

  task automatic set_quiet_exp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_fto = 1'b0; exp_ld = model_ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0; alu = $urandom; mask = 4'($urandom); wd = $urandom;
      bus.bus_ack = 1'($urandom_range(0, 1));
      bus.bus_rdata = $urandom;
      set_quiet_exp();
    end
  endtask

  // One access: IDLE cycle, optional REQ cycles answered after ack_dly cycles, then DONE.
  task automatic issue(input logic r, input logic w, input logic [3:0] m, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input int ack_dly,
                       input logic [31:0] rdata);
    logic bad, tmo;
    int   off, n;
    off = int'(a[1:0]);
    bad = (r && w) || !(m == 4'b0001 || m == 4'b0011 || m == 4'b1111) ||
          (m == 4'b0011 && a[0]) || (m == 4'b1111 && off != 0);
    tmo = ack_dly > TMO;
    n   = tmo ? TMO : ack_dly;

    @(posedge clk); #1;
    rd = r; wr = w; mask = m; sx = s; alu = a; wd = d; bus.bus_ack = 1'b0;
    set_quiet_exp();
    exp_stall = 1'b1;

    if (bad) begin
      @(posedge clk); #1;
      bus.bus_ack = 1'($urandom_range(0, 1));
      set_quiet_exp();
      exp_fault = 1'b1;
    end else begin
      for (int c = 1; c <= n; c++) begin
        @(posedge clk); #1;
        bus.bus_ack   = !tmo && (c == n);
        bus.bus_rdata = (!tmo && c == n) ? rdata : $urandom;
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = w;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_wdata = d << (8 * off);
        exp_wstrb = w ? (m << off) : 4'b0000;
      end
      @(posedge clk); #1;
      bus.bus_ack = 1'($urandom_range(0, 1));
      bus.bus_rdata = $urandom;
      if (!tmo && r) model_ld = model_align(rdata, off, m, s);
      set_quiet_exp();
      exp_fault = tmo;
      exp_fto   = tmo;
    end
  endtask

  task automatic reset_mid_req();
    @(posedge clk); #1;
    rd = 1'b1; wr = 1'b0; mask = 4'b1111; sx = 1'b0; alu = 32'h80; bus.bus_ack = 1'b0;
    set_quiet_exp();
    exp_stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h80; exp_wstrb = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    model_ld = 32'h0;
    set_quiet_exp();
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    set_quiet_exp();
    check("rst_load_data", ld, 32'h0);
    check("rst_bus_req", 32'(bus.bus_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; alu = '0; mask = '0; sx = 1'b0; wd = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0; model_ld = '0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    set_quiet_exp();
    exp_on = 1'b1;
    @(negedge clk);
    check("reset_we", 32'(bus.bus_we), 32'h0);
    check("reset_addr", bus.bus_addr, 32'h0);
    check("reset_wdata", bus.bus_wdata, 32'h0);
    check("reset_wstrb", 32'(bus.bus_wstrb), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Word store, ack in third REQ cycle.
    clr();
    issue(1'b0, 1'b1, 4'hF, 1'b0, 32'h100, 32'hDEAD_BEEF, 3, 32'h0);
    idle(1);
    check("ws_addr", cap_addr, 32'h100);
    check("ws_wstrb", 32'(cap_wstrb), 32'hF);
    check("ws_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("ws_we", 32'(cap_we), 32'h1);
    check("ws_stall_cycles", 32'(stall_cnt), 32'd4);

    // Byte loads from offset 3, signed then unsigned.
    issue(1'b1, 1'b0, 4'h1, 1'b1, 32'h203, 32'h0, 2, 32'h80FF_0000);
    idle(1);
    check("lb_signed", ld, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 4'h1, 1'b0, 32'h203, 32'h0, 1, 32'h80FF_0000);
    idle(1);
    check("lb_unsigned", ld, 32'h0000_0080);

    // Half store to upper lanes.
    clr();
    issue(1'b0, 1'b1, 4'h3, 1'b0, 32'h12, 32'h0000_ABCD, 2, 32'h0);
    idle(1);
    check("hs_wstrb", 32'(cap_wstrb), 32'hC);
    check("hs_wdata", cap_wdata, 32'hABCD_0000);
    check("hs_addr", cap_addr, 32'h10);
    check("hs_load_kept", ld, 32'h0000_0080);

    // Misaligned word load.
    clr();
    issue(1'b1, 1'b0, 4'hF, 1'b0, 32'h101, 32'h0, 1, 32'h0);
    idle(1);
    check("mis_stall_cycles", 32'(stall_cnt), 32'd1);
    check("mis_req_cycles", 32'(req_cnt), 32'd0);
    check("mis_fault", 32'(fault_cnt), 32'd1);
    check("mis_fault_timeout", 32'(fto_cnt), 32'd0);

    // Timeout after four REQ cycles leaves the last load value intact.
    issue(1'b1, 1'b0, 4'hF, 1'b0, 32'h0, 32'h0, 1, 32'h1234_5678);
    idle(1);
    check("lw_value", ld, 32'h1234_5678);
    clr();
    issue(1'b1, 1'b0, 4'hF, 1'b1, 32'h44, 32'h0, 99, 32'h0);
    idle(1);
    check("to_req_cycles", 32'(req_cnt), 32'd4);
    check("to_fault", 32'(fault_cnt), 32'd1);
    check("to_fault_timeout", 32'(fto_cnt), 32'd1);
    check("to_load_kept", ld, 32'h1234_5678);

    // Ack on the timeout cycle completes normally.
    clr();
    issue(1'b1, 1'b0, 4'hF, 1'b0, 32'h48, 32'h0, TMO, 32'hCAFE_F00D);
    idle(1);
    check("late_ack_fault", 32'(fault_cnt), 32'd0);
    check("late_ack_value", ld, 32'hCAFE_F00D);

    reset_mid_req();
    idle(1);

    for (int t = 0; t < 300; t++) begin
      int          kind, dly;
      logic        r, w, s;
      logic [3:0]  m;
      logic [31:0] a;
      kind = $urandom_range(0, 19);
      dly  = $urandom_range(1, 6);
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      case ($urandom_range(0, 2))
        0:       m = 4'b0001;
        1:       m = 4'b0011;
        default: m = 4'b1111;
      endcase
      r = kind < 9 || kind >= 17;
      w = (kind >= 9 && kind < 17) || kind == 17;
      if (kind == 18) m = 4'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (m == 4'b1111) a[1:0] = 2'b00;
        else if (m == 4'b0011) a[0] = 1'b0;
      end
      if (kind == 19) idle(1);
      else issue(r, w, m, s, a, $urandom, dly, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    exp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
